// File: rtl/spm_stream_ctrl.sv
// Framing controller: parses sync/length/sample frames from the UART rx FIFO into the SPM,
// and returns the processed samples to the UART tx FIFO as an equal-length reply frame.
module spm_stream_ctrl #(
    parameter logic [7:0] SYNC_IN        = 8'hA5,
    parameter logic [7:0] SYNC_OUT       = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rx_read,
    output logic [7:0]  tx_data,
    input  logic        tx_full,
    output logic        tx_write,
    output logic [15:0] sample_in,
    output logic        sample_in_valid,
    input  logic        sample_in_ready,
    input  logic [15:0] sample_out,
    input  logic        sample_out_valid,
    output logic        sample_out_ready,
    output logic        busy,
    output logic        frame_error,
    output logic [7:0]  frame_count
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {R_IDLE, R_LEN, R_LO, R_HI, R_PUSH, R_PAD} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_SYNC, T_LEN, T_WAIT, T_LO, T_HI} tx_state_t;

    rx_state_t       rx_state, rx_next;
    tx_state_t       tx_state, tx_next;
    logic [7:0]      rx_rem, tx_rem, lo_byte;
    logic [15:0]     tx_sample;
    logic [CW-1:0]   idle_cnt;
    logic            rx_pop_state, tx_send_state, timed_state;
    logic            timeout, tx_start, set_error, in_fire, out_fire;

    // A new request is only accepted once the previous reply has fully left.
    assign rx_pop_state  = (rx_state == R_IDLE) ? (tx_state == T_IDLE)
                         : (rx_state inside {R_LEN, R_LO, R_HI});
    assign timed_state   = rx_state inside {R_LEN, R_LO, R_HI};
    assign tx_send_state = tx_state inside {T_SYNC, T_LEN, T_LO, T_HI};

    assign rx_read          = rx_pop_state & ~rx_empty & enable;
    assign tx_write         = tx_send_state & ~tx_full & enable;
    assign sample_in_valid  = (rx_state inside {R_PUSH, R_PAD}) & enable;
    assign sample_out_ready = (tx_state == T_WAIT) & enable;
    assign in_fire          = sample_in_valid & sample_in_ready;
    assign out_fire         = sample_out_ready & sample_out_valid;
    assign timeout          = timed_state & enable & rx_empty & (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign busy             = (rx_state != R_IDLE) | (tx_state != T_IDLE);

    always_comb begin
        rx_next   = rx_state;
        tx_next   = tx_state;
        tx_start  = 1'b0;
        set_error = 1'b0;
        tx_data   = 8'h00;
        case (rx_state)
            R_IDLE: if (rx_read && rx_data == SYNC_IN) rx_next = R_LEN;
            R_LEN: begin
                if (rx_read) begin
                    if (rx_data == 8'h00) begin
                        set_error = 1'b1;
                        rx_next   = R_IDLE;
                    end else begin
                        tx_start = 1'b1;
                        rx_next  = R_LO;
                    end
                end else if (timeout) begin
                    set_error = 1'b1;
                    rx_next   = R_IDLE;
                end
            end
            R_LO, R_HI: begin
                if (rx_read) begin
                    rx_next = (rx_state == R_LO) ? R_HI : R_PUSH;
                end else if (timeout) begin
                    set_error = 1'b1;
                    rx_next   = R_PAD;
                end
            end
            R_PUSH: if (in_fire) rx_next = (rx_rem == 8'd1) ? R_IDLE : R_LO;
            R_PAD:  if (in_fire && rx_rem == 8'd1) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase

        case (tx_state)
            T_IDLE: if (tx_start) tx_next = T_SYNC;
            T_SYNC: begin
                tx_data = SYNC_OUT;
                if (tx_write) tx_next = T_LEN;
            end
            T_LEN: begin
                tx_data = tx_rem;
                if (tx_write) tx_next = T_WAIT;
            end
            T_WAIT: if (out_fire) tx_next = T_LO;
            T_LO: begin
                tx_data = tx_sample[7:0];
                if (tx_write) tx_next = T_HI;
            end
            T_HI: begin
                tx_data = tx_sample[15:8];
                if (tx_write) tx_next = (tx_rem == 8'd1) ? T_IDLE : T_WAIT;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= R_IDLE;
            tx_state <= T_IDLE;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_rem      <= '0;
            tx_rem      <= '0;
            lo_byte     <= '0;
            sample_in   <= '0;
            tx_sample   <= '0;
            idle_cnt    <= '0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            if (set_error) frame_error <= 1'b1;

            // Idle counter only runs while mid-frame and waiting on the rx FIFO.
            if (!timed_state || rx_read || timeout) idle_cnt <= '0;
            else if (enable && rx_empty)           idle_cnt <= idle_cnt + 1'b1;

            if (tx_start) begin
                rx_rem <= rx_data;
                tx_rem <= rx_data;
            end
            if (rx_state == R_LO && rx_read) lo_byte <= rx_data;
            if (rx_state == R_HI && rx_read) sample_in <= {rx_data, lo_byte};
            if (timeout && rx_state != R_LEN) sample_in <= 16'h0000;
            if (in_fire) rx_rem <= rx_rem - 1'b1;

            if (out_fire) tx_sample <= sample_out;
            if (tx_state == T_HI && tx_write) begin
                tx_rem <= tx_rem - 1'b1;
                if (tx_rem == 8'd1) frame_count <= frame_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spm_stream_ctrl.sv
// Bench for spm_stream_ctrl: FIFO and loopback-SPM models around the DUT, with replies checked
// against a frame-level model of what the byte stream should produce.
module tb_spm_stream_ctrl;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_full = 1'b0;
    logic        tx_write;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic        sample_in_ready = 1'b1;
    logic [15:0] sample_out = 16'h0000;
    logic        sample_out_valid = 1'b0;
    logic        sample_out_ready;
    logic        busy;
    logic        frame_error;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    spm_stream_ctrl #(
        .SYNC_IN(8'hA5),
        .SYNC_OUT(8'h5A),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .rx_data(rx_data),
        .rx_empty(rx_empty),
        .rx_read(rx_read),
        .tx_data(tx_data),
        .tx_full(tx_full),
        .tx_write(tx_write),
        .sample_in(sample_in),
        .sample_in_valid(sample_in_valid),
        .sample_in_ready(sample_in_ready),
        .sample_out(sample_out),
        .sample_out_valid(sample_out_valid),
        .sample_out_ready(sample_out_ready),
        .busy(busy),
        .frame_error(frame_error),
        .frame_count(frame_count)
    );

    byte_q_t     rx_q, tx_got, exp_q;
    logic [15:0] spm_q[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_fc = 0;
    bit          exp_err = 1'b0;
    bit          exp_err_sticky = 1'b0;
    int          gap_pct = 0, full_pct = 0, nrdy_pct = 0, en_off_pct = 0, gap_run = 0;
    bit          hold_full = 1'b0;

    // rx FIFO head advances on the edge where rx_read is high
    always @(posedge clk) if (rx_read) void'(rx_q.pop_front());

    always @(posedge clk) if (tx_write) tx_got.push_back(tx_data);

    // Loopback SPM with one cycle of latency; stalls rather than drops
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            spm_q.delete();
            sample_out_valid <= 1'b0;
            sample_out       <= 16'h0000;
        end else begin
            if (sample_out_valid && sample_out_ready) void'(spm_q.pop_front());
            if (sample_in_valid && sample_in_ready) spm_q.push_back(sample_in);
            sample_out_valid <= (spm_q.size() > 0);
            sample_out       <= (spm_q.size() > 0) ? spm_q[0] : 16'h0000;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit gap;
        @(negedge clk);
        if (gap_pct > 0 && gap_run < 3 && $urandom_range(0, 99) < gap_pct) begin
            gap = 1'b1;
            gap_run++;
        end else begin
            gap = 1'b0;
            gap_run = 0;
        end
        rx_empty        = (rx_q.size() == 0) || gap;
        rx_data         = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        tx_full         = hold_full || ($urandom_range(0, 99) < full_pct);
        sample_in_ready = ($urandom_range(0, 99) >= nrdy_pct);
        enable          = ($urandom_range(0, 99) >= en_off_pct);
        #1;
        if (!enable)
            check("en_freeze", {28'h0, rx_read, tx_write, sample_in_valid, sample_out_ready}, 32'h0);
    endtask

    // Frame-level expectation: skip to sync, read N, echo N samples; a stream that ends early
    // keeps its complete samples and zero-fills the rest, flagging an error.
    task automatic model_frame(input byte_q_t in);
        int i;
        int n;
        i = 0;
        exp_q.delete();
        exp_err = 1'b0;
        while (i < in.size() && in[i] != 8'hA5) i++;
        if (i >= in.size()) return;
        i++;
        if (i >= in.size()) begin
            exp_err = 1'b1;
            return;
        end
        n = int'(in[i]);
        i++;
        if (n == 0) begin
            exp_err = 1'b1;
            return;
        end
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            if (i + 1 < in.size()) begin
                exp_q.push_back(in[i]);
                exp_q.push_back(in[i + 1]);
            end else begin
                exp_err = 1'b1;
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h00);
            end
            i += 2;
        end
    endtask

    task automatic start_frame(input byte_q_t b);
        model_frame(b);
        if (exp_q.size() > 0) exp_fc++;
        if (exp_err) exp_err_sticky = 1'b1;
        tx_got.delete();
        foreach (b[i]) rx_q.push_back(b[i]);
    endtask

    task automatic finish_frame(input string tag);
        bit done;
        logic [31:0] obs;
        done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (rx_q.size() == 0 && !busy && tx_got.size() >= exp_q.size()) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        repeat (4) step();
        check({tag, "_len"}, tx_got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < tx_got.size()) ? {24'h0, tx_got[i]} : 32'hFFFF_FFFF;
            check($sformatf("%s_b%0d", tag, i), obs, {24'h0, exp_q[i]});
        end
        check({tag, "_count"}, {24'h0, frame_count}, 32'(exp_fc % 256));
        check({tag, "_err"}, {31'h0, frame_error}, {31'h0, exp_err_sticky});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_fc = 0;
        exp_err_sticky = 1'b0;
        tx_got.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_err"}, {31'h0, frame_error}, 32'h0);
        check({tag, "_count"}, {24'h0, frame_count}, 32'h0);
        check({tag, "_sample_in"}, {16'h0, sample_in}, 32'h0);
        check({tag, "_strobes"}, {28'h0, rx_read, tx_write, sample_in_valid, sample_out_ready}, 32'h0);
    endtask

    initial begin
        byte_q_t    b;
        int         n;
        int         viol;
        logic [7:0] g;

        repeat (3) @(negedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b0;

        b = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
        start_frame(b);
        finish_frame("loop");

        // Garbage ahead of the sync byte must drain at one byte per cycle
        b = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h5E, 8'hC3};
        start_frame(b);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("garbage_pop%0d", i), {31'h0, rx_read}, 32'h1);
        end
        finish_frame("garbage");

        b = '{8'hA5, 8'h00};
        start_frame(b);
        finish_frame("len0");
        b = '{8'hA5, 8'h01, 8'hAA, 8'h55};
        start_frame(b);
        finish_frame("after_len0");
        do_reset();

        b = '{8'hA5, 8'h03, 8'h11, 8'h22};
        start_frame(b);
        finish_frame("timeout");
        do_reset();

        // tx FIFO full for 50 cycles from the start of an N=4 frame
        b = '{8'hA5, 8'h04};
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom_range(0, 255)));
        start_frame(b);
        hold_full = 1'b1;
        viol = 0;
        repeat (50) begin
            step();
            if (tx_write || sample_out_ready) viol++;
        end
        check("hold_stall", viol, 0);
        hold_full = 1'b0;
        finish_frame("hold");

        // Reset while the RX side is waiting for a high byte
        b = '{8'hA5, 8'h02, 8'h34};
        foreach (b[i]) rx_q.push_back(b[i]);
        repeat (6) step();
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        step();
        step();
        reset = 1'b0;
        exp_fc = 0;
        exp_err_sticky = 1'b0;
        b = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h21, 8'h43};
        start_frame(b);
        finish_frame("post_rst");

        gap_pct = 25;
        full_pct = 25;
        nrdy_pct = 25;
        for (int f = 0; f < 10; f++) begin
            if (f >= 7) en_off_pct = 25;
            b.delete();
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                b.push_back(g);
            end
            n = $urandom_range(1, 10);
            b.push_back(8'hA5);
            b.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) b.push_back(8'($urandom_range(0, 255)));
            start_frame(b);
            finish_frame($sformatf("rand%0d", f));
        end
        en_off_pct = 0;
        gap_pct = 0;
        full_pct = 0;
        nrdy_pct = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
